// File: rtl/ntt_pair_sequencer.sv
// Kyber NTT/INTT butterfly pair sequencer: issues (j, j+len, k, sel) per cycle.
// Optional INTT scaling pass enabled by NTT_PAIR_SEQUENCER_INTT_SCALE_EN.
module ntt_pair_sequencer #(
    parameter int ADDRW  = 8,
    parameter int ZADDRW = 7,
    parameter int SELWID = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    output logic              busy,
    output logic              done,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [ADDRW-1:0]  addr0,
    output logic [ADDRW-1:0]  addr1,
    output logic [ZADDRW-1:0] zeta_addr,
    output logic [SELWID-1:0] sel,
    output logic              last
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
`ifdef NTT_PAIR_SEQUENCER_INTT_SCALE_EN
        , S_SCALE
`endif
    } state_t;

    state_t            r_state;
    logic              r_mode;
    logic [2:0]        r_layer;
    logic [6:0]        r_b;
    logic              r_busy;
    logic              r_done;
    logic              r_valid;
    logic              r_last;
    logic [ADDRW-1:0]  r_addr0;
    logic [ADDRW-1:0]  r_addr1;
    logic [ZADDRW-1:0] r_zeta;
    logic [SELWID-1:0] r_sel;

    logic              w_load;
    logic              w_b_wrap;
    logic              w_final;
    logic              w_scale_on;
    logic [6:0]        w_b_n;
    logic [2:0]        w_layer_n;
    logic [2:0]        w_lg;
    logic [7:0]        w_bx;
    logic [7:0]        w_len;
    logic [7:0]        w_grp;
    logic [7:0]        w_a0;
    logic [7:0]        w_a1;
    logic [6:0]        w_zn;
    logic [6:0]        w_zi;
    logic [6:0]        w_z;
    logic [SELWID-1:0] w_sel;
    logic              w_last_n;

    // Next (layer, b) is what the registered outputs will present after this edge.
    assign w_load    = (r_state == S_LOAD);
    assign w_b_wrap  = (r_b == 7'd127);
    assign w_final   = w_b_wrap && (r_layer == 3'd6);
    assign w_b_n     = w_load ? 7'd0 : r_b + 7'd1;
    assign w_layer_n = w_load ? 3'd0 : r_layer + {2'b00, w_b_wrap};
    assign w_lg      = r_mode ? w_layer_n + 3'd1 : 3'd7 - w_layer_n;

    assign w_bx  = {1'b0, w_b_n};
    assign w_len = 8'd1 << w_lg;
    assign w_grp = w_bx >> w_lg;
    assign w_a0  = (w_grp << ({1'b0, w_lg} + 4'd1)) | (w_bx & (w_len - 8'd1));
    assign w_a1  = w_a0 + w_len;

    // INTT top term 1<<7 wraps to 0 in 7 bits; the modular result is still exact.
    assign w_zn = (7'd1 << (3'd7 - w_lg)) + w_grp[6:0];
    assign w_zi = (7'd1 << (4'd8 - {1'b0, w_lg})) - 7'd1 - w_grp[6:0];
    assign w_z  = r_mode ? w_zi : w_zn;

    assign w_sel = {{(SELWID-5){1'b0}}, w_layer_n, 1'b0, r_mode};

`ifdef NTT_PAIR_SEQUENCER_INTT_SCALE_EN
    assign w_scale_on = r_mode;
`else
    assign w_scale_on = 1'b0;
`endif

    assign w_last_n = (w_layer_n == 3'd6) && (w_b_n == 7'd127) && !w_scale_on;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_mode  <= 1'b0;
            r_layer <= 3'd0;
            r_b     <= 7'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_addr0 <= '0;
            r_addr1 <= '0;
            r_zeta  <= '0;
            r_sel   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state <= S_LOAD;
                        r_busy  <= 1'b1;
                        r_mode  <= mode;
                        r_layer <= 3'd0;
                        r_b     <= 7'd0;
                    end
                end
                S_LOAD: begin
                    r_state <= S_RUN;
                    r_valid <= 1'b1;
                    r_layer <= w_layer_n;
                    r_b     <= w_b_n;
                    r_addr0 <= ADDRW'(w_a0);
                    r_addr1 <= ADDRW'(w_a1);
                    r_zeta  <= ZADDRW'(w_z);
                    r_sel   <= w_sel;
                    r_last  <= 1'b0;
                end
                S_RUN: begin
                    if (op_ready) begin
                        if (w_final) begin
`ifdef NTT_PAIR_SEQUENCER_INTT_SCALE_EN
                            if (r_mode) begin
                                r_state <= S_SCALE;
                                r_b     <= w_b_n;
                                r_addr0 <= ADDRW'({w_b_n, 1'b0});
                                r_addr1 <= ADDRW'({w_b_n, 1'b1});
                                r_zeta  <= '0;
                                r_sel   <= SELWID'(5'b11111);
                                r_last  <= 1'b0;
                            end else
`endif
                            begin
                                r_state <= S_DONE;
                                r_valid <= 1'b0;
                                r_last  <= 1'b0;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_layer <= w_layer_n;
                            r_b     <= w_b_n;
                            r_addr0 <= ADDRW'(w_a0);
                            r_addr1 <= ADDRW'(w_a1);
                            r_zeta  <= ZADDRW'(w_z);
                            r_sel   <= w_sel;
                            r_last  <= w_last_n;
                        end
                    end
                end
`ifdef NTT_PAIR_SEQUENCER_INTT_SCALE_EN
                S_SCALE: begin
                    if (op_ready) begin
                        if (w_b_wrap) begin
                            r_state <= S_DONE;
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_b     <= w_b_n;
                            r_addr0 <= ADDRW'({w_b_n, 1'b0});
                            r_addr1 <= ADDRW'({w_b_n, 1'b1});
                            r_last  <= (w_b_n == 7'd127);
                        end
                    end
                end
`endif
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign op_valid  = r_valid;
    assign last      = r_last;
    assign addr0     = r_addr0;
    assign addr1     = r_addr1;
    assign zeta_addr = r_zeta;
    assign sel       = r_sel;

endmodule

// File: tb/tb_ntt_pair_sequencer.sv
// Bench for ntt_pair_sequencer: reference loop-nest model, vector table, stalls, reset abort.
// Honours NTT_PAIR_SEQUENCER_INTT_SCALE_EN when building expectations.
module tb_ntt_pair_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic       op_ready = 1'b0;
    logic       busy, done, op_valid, last;
    logic [7:0] addr0, addr1;
    logic [6:0] zeta_addr;
    logic [8:0] sel;

    always #5 clk = ~clk;

    ntt_pair_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .busy      (busy),
        .done      (done),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .addr0     (addr0),
        .addr1     (addr1),
        .zeta_addr (zeta_addr),
        .sel       (sel),
        .last      (last)
    );

    typedef struct packed {
        logic [7:0] a0;
        logic [7:0] a1;
        logic [6:0] z;
        logic [8:0] sel;
        logic       last;
    } pair_t;

    typedef struct {
        bit    m;
        int    idx;
        pair_t exp;
    } vec_t;

    pair_t obs[$];
    pair_t ref_q[$];
    pair_t obs_ntt[$];
    pair_t obs_intt[$];
    vec_t  vecs[$];

    int n_pass = 0;
    int n_chk  = 0;
    int done_cyc;
    int stall_err;
    int busy_err;
    bit aborted;

    task automatic check(input string name, input bit ok, input string info);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: %s", name, info);
    endtask

    function automatic string fmt(input pair_t p);
        return $sformatf("%0d/%0d z=%0d sel=%h last=%b", p.a0, p.a1, p.z, p.sel, p.last);
    endfunction

    // Kyber reference loop nest: for len, for start, for j -> (j, j+len, k).
    function automatic void build_ref(input bit m);
        pair_t p;
        int    k;
        int    layer;
        ref_q.delete();
        layer = 0;
        p.last = 1'b0;
        if (!m) begin
            k = 1;
            for (int len = 128; len >= 2; len = len / 2) begin
                for (int st = 0; st < 256; st += 2 * len) begin
                    for (int j = st; j < st + len; j++) begin
                        p.a0 = 8'(j); p.a1 = 8'(j + len); p.z = 7'(k);
                        p.sel = 9'(layer * 4);
                        ref_q.push_back(p);
                    end
                    k++;
                end
                layer++;
            end
        end else begin
            k = 127;
            for (int len = 2; len <= 128; len = len * 2) begin
                for (int st = 0; st < 256; st += 2 * len) begin
                    for (int j = st; j < st + len; j++) begin
                        p.a0 = 8'(j); p.a1 = 8'(j + len); p.z = 7'(k);
                        p.sel = 9'(layer * 4 + 1);
                        ref_q.push_back(p);
                    end
                    k--;
                end
                layer++;
            end
`ifdef NTT_PAIR_SEQUENCER_INTT_SCALE_EN
            for (int i = 0; i < 128; i++) begin
                p.a0 = 8'(2 * i); p.a1 = 8'(2 * i + 1); p.z = 7'd0;
                p.sel = 9'h01F;
                ref_q.push_back(p);
            end
`endif
        end
        p = ref_q[ref_q.size() - 1];
        p.last = 1'b1;
        ref_q[ref_q.size() - 1] = p;
    endfunction

    function automatic int first_diff();
        int n;
        n = (obs.size() < ref_q.size()) ? obs.size() : ref_q.size();
        for (int i = 0; i < n; i++)
            if (obs[i] != ref_q[i]) return i;
        return -1;
    endfunction

    function automatic vec_t mk(input bit m, input int idx, input int a0, input int a1,
                                input int z, input int s, input bit l);
        vec_t v;
        v.m = m; v.idx = idx;
        v.exp.a0 = 8'(a0); v.exp.a1 = 8'(a1); v.exp.z = 7'(z);
        v.exp.sel = 9'(s); v.exp.last = l;
        return v;
    endfunction

    task automatic run_xform(input bit m, input int pct, input int abort_at, input bit poke);
        pair_t cur, prev;
        bit    prev_v, prev_r;
        bit    bad;
        obs.delete();
        done_cyc = -1; stall_err = 0; busy_err = 0; aborted = 0;
        prev_v = 0; prev_r = 0; prev = '0;
        @(negedge clk);
        mode = m; start = 1'b1; op_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc < 3000; cyc++) begin
            cur = '{addr0, addr1, zeta_addr, sel, last};
            if (done) begin
                done_cyc = cyc;
                if (busy) busy_err++;
                break;
            end
            if (!busy) busy_err++;
            if (prev_v && !prev_r && (!op_valid || cur != prev)) stall_err++;
            if (poke && (cyc == 50 || cyc == 400)) begin
                start = 1'b1; mode = ~m;
            end else begin
                start = 1'b0;
            end
            op_ready = ($urandom_range(0, 99) < pct);
            if (op_valid && op_ready) begin
                obs.push_back(cur);
                if (abort_at > 0 && obs.size() == abort_at) begin
                    rst = 1'b0; aborted = 1;
                    break;
                end
            end
            prev = cur; prev_v = op_valid; prev_r = op_ready;
            @(negedge clk);
        end
        start = 1'b0;
        if (aborted) begin
            @(negedge clk);
            check("abort_outputs", !op_valid && !busy && !done && !last,
                  $sformatf("valid=%b busy=%b done=%b last=%b, want all 0",
                            op_valid, busy, done, last));
            rst = 1'b1;
            bad = 0;
            repeat (5) begin
                @(negedge clk);
                if (done || busy || op_valid) bad = 1;
            end
            check("abort_quiet", !bad, $sformatf("activity after abort=%b, want 0", bad));
        end else if (poke && done_cyc > 0) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("start_on_done_1", !busy && !op_valid,
                  $sformatf("busy=%b valid=%b, want 0/0", busy, op_valid));
            @(negedge clk);
            check("start_on_done_2", !busy && !op_valid,
                  $sformatf("busy=%b valid=%b, want 0/0", busy, op_valid));
        end
        op_ready = 1'b0;
        mode = m;
    endtask

    task automatic check_run(input string tag, input bit m, input bit timed);
        int d;
        build_ref(m);
        check({tag, "_count"}, obs.size() == ref_q.size(),
              $sformatf("transfers=%0d, want %0d", obs.size(), ref_q.size()));
        d = first_diff();
        check({tag, "_seq"}, d < 0,
              (d < 0) ? "" : $sformatf("pair %0d got %s want %s", d, fmt(obs[d]), fmt(ref_q[d])));
        check({tag, "_stall"}, stall_err == 0, $sformatf("stall violations=%0d, want 0", stall_err));
        check({tag, "_busy"}, busy_err == 0, $sformatf("busy errors=%0d, want 0", busy_err));
        if (timed)
            check({tag, "_latency"}, done_cyc == 2 + ref_q.size(),
                  $sformatf("done at cycle %0d, want %0d", done_cyc, 2 + ref_q.size()));
        else
            check({tag, "_done"}, done_cyc > 0, $sformatf("done cycle=%0d, want >0", done_cyc));
    endtask

    initial begin
        pair_t g;
        vecs.push_back(mk(0, 0,   0, 128, 1,   9'h000, 0));
        vecs.push_back(mk(0, 192, 128, 192, 3, 9'h004, 0));
        vecs.push_back(mk(0, 895, 253, 255, 127, 9'h018, 1));
        vecs.push_back(mk(1, 0,   0, 2, 127,   9'h001, 0));
        vecs.push_back(mk(1, 1,   1, 3, 127,   9'h001, 0));
        vecs.push_back(mk(1, 2,   4, 6, 126,   9'h001, 0));
`ifdef NTT_PAIR_SEQUENCER_INTT_SCALE_EN
        vecs.push_back(mk(1, 895, 127, 255, 1, 9'h019, 0));
        vecs.push_back(mk(1, 896, 0, 1, 0,     9'h01F, 0));
        vecs.push_back(mk(1, 1023, 254, 255, 0, 9'h01F, 1));
`else
        vecs.push_back(mk(1, 895, 127, 255, 1, 9'h019, 1));
`endif

        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state",
              !busy && !done && !op_valid && !last && addr0 == 0 && addr1 == 0
              && zeta_addr == 0 && sel == 0,
              $sformatf("busy=%b done=%b valid=%b last=%b a=%0d/%0d z=%0d sel=%h, want zeros",
                        busy, done, op_valid, last, addr0, addr1, zeta_addr, sel));
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_no_start", !busy && !op_valid,
              $sformatf("busy=%b valid=%b, want 0/0", busy, op_valid));

        run_xform(0, 100, 0, 0);
        check_run("ntt_full", 0, 1);
        obs_ntt = obs;

        run_xform(1, 100, 0, 0);
        check_run("intt_full", 1, 1);
        obs_intt = obs;

        foreach (vecs[i]) begin
            if (vecs[i].m) begin
                if (vecs[i].idx < obs_intt.size()) g = obs_intt[vecs[i].idx];
                else g = '1;
            end else begin
                if (vecs[i].idx < obs_ntt.size()) g = obs_ntt[vecs[i].idx];
                else g = '1;
            end
            check($sformatf("vec%0d_m%0d_p%0d", i, vecs[i].m, vecs[i].idx), g == vecs[i].exp,
                  $sformatf("got %s want %s", fmt(g), fmt(vecs[i].exp)));
        end

        run_xform(0, 50, 0, 1);
        check_run("ntt_rand_poke", 0, 0);

        run_xform(1, 50, 0, 1);
        check_run("intt_rand_poke", 1, 0);

        run_xform(0, 70, 300, 0);
        check("abort_count", obs.size() == 300,
              $sformatf("transfers before abort=%0d, want 300", obs.size()));

        run_xform(0, 50, 0, 0);
        g = (obs.size() > 0) ? obs[0] : '1;
        check("restart_first", g == pair_t'({8'd0, 8'd128, 7'd1, 9'h000, 1'b0}),
              $sformatf("got %s want 0/128 z=1 sel=000 last=0", fmt(g)));
        check_run("ntt_restart", 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
